// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Master drives start and the operands; slave returns status and the result.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  // start is looked at only while the slave is idle.
  // busy is high for the WIDTH bit cycles; done is a one-cycle pulse with d/bout valid.
  modport master (output start, a, b, bin, input busy, done, d, bout);
  modport slave  (input start, a, b, bin, output busy, done, d, bout);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial borrow-ripple subtractor: {bout,d} = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell and one borrow flop; the result is committed on the last bit.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus,
  output logic [1:0]          state_o
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;

  logic             ai, bi, diff_bit, br_next;
  logic [WIDTH:0]   sr_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    bout_d   = bout_q;

    ai       = sa_q[0];
    bi       = sb_q[0];
    diff_bit = ai ^ bi ^ br_q;
    br_next  = (~ai & bi) | (~(ai ^ bi) & br_q);
    // New difference bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    sr_ext   = {diff_bit, sr_q};

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          br_d    = bus.bin;
          sr_d    = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sr_d  = sr_ext[WIDTH:1];
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = br_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          d_d     = sr_ext[WIDTH:1];
          bout_d  = br_next;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.d    = d_q;
  assign bus.bout = bout_q;
  assign state_o  = state_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=4 and WIDTH=8 instances share one stimulus stream,
// each checked every cycle against an arithmetic model of result and timing.
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_s = 1'b0;
  logic [7:0] a_s = 8'h00;
  logic [7:0] b_s = 8'h00;
  logic       bin_s = 1'b0;
  logic [1:0] st4, st8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  serial_subtractor_if #(.WIDTH(4)) bus4 ();
  serial_subtractor_if #(.WIDTH(8)) bus8 ();

  assign bus4.start = start_s;
  assign bus4.a     = a_s[3:0];
  assign bus4.b     = b_s[3:0];
  assign bus4.bin   = bin_s;
  assign bus8.start = start_s;
  assign bus8.a     = a_s;
  assign bus8.b     = b_s;
  assign bus8.bin   = bin_s;

  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4), .state_o(st4));
  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8), .state_o(st8));

  // clock / reset
  always #5 clk = ~clk;

  // model state, index 0 -> WIDTH 4, index 1 -> WIDTH 8
  int         w_of[2] = '{4, 8};
  int         acc_q[2][$];
  logic [8:0] exp_q[2][$];
  logic [8:0] hold[2];
  int         next_free[2];
  int         ops[2];

  logic [8:0] res4, res8;
  assign res4 = {4'b0, bus4.bout, bus4.d};
  assign res8 = {bus8.bout, bus8.d};

  task automatic chk(input string name, input int idx, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [w=%0d] at cycle %0d: got=%0h want=%0h", name, w_of[idx], cyc, act, exp);
    end
  endtask

  // (a - b - bin) mod 2^(w+1); bit w is the borrow-out
  function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b,
                                         input logic bin, input int w);
    int av, bv, diff;
    av   = int'(a) & ((1 << w) - 1);
    bv   = int'(b) & ((1 << w) - 1);
    diff = av - bv - int'(bin);
    if (diff < 0) diff += (1 << (w + 1));
    return 9'(diff);
  endfunction

  // model: an operation is accepted on any edge with start high once the unit is free again
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        acc_q[i].delete();
        exp_q[i].delete();
        hold[i]      = '0;
        next_free[i] = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (start_s && cyc >= next_free[i]) begin
          acc_q[i].push_back(cyc);
          exp_q[i].push_back(ref_sub(a_s, b_s, bin_s, w_of[i]));
          next_free[i] = cyc + w_of[i] + 2;
        end
      end
    end
  end

  // scoreboard: busy/done/result on every cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   k;
      logic eb, ed;
      eb = 1'b0;
      ed = 1'b0;
      if (acc_q[i].size() > 0) begin
        k  = acc_q[i][0];
        eb = (cyc >= k) && (cyc < k + w_of[i]);
        ed = (cyc == k + w_of[i]);
      end
      chk("busy", i, {8'b0, (i == 0) ? bus4.busy : bus8.busy}, {8'b0, eb});
      chk("done", i, {8'b0, (i == 0) ? bus4.done : bus8.done}, {8'b0, ed});
      if (ed) begin
        hold[i] = exp_q[i].pop_front();
        void'(acc_q[i].pop_front());
        ops[i]++;
      end
      chk("result", i, (i == 0) ? res4 : res8, hold[i]);
    end
  end

  // driver tasks
  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus4.busy || bus4.done || bus8.busy || bus8.done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 0, 9'(n < 100), 9'd1);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi,
                     input logic [3:0] exp_d, input logic exp_bout);
    int n;
    bit seen;
    wait_idle();
    @(negedge clk);
    a_s     = {4'($urandom), a};
    b_s     = {4'($urandom), b};
    bin_s   = bi;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    a_s     = 8'($urandom);
    b_s     = 8'($urandom);
    bin_s   = 1'($urandom_range(0, 1));
    n       = 1;
    seen    = 0;
    while (!seen && n < 30) begin
      if (bus4.done) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("latency", 0, 9'(n), 9'd5);
    if (seen) begin
      chk("lit_d", 0, {5'b0, bus4.d}, {5'b0, exp_d});
      chk("lit_bout", 0, {8'b0, bus4.bout}, {8'b0, exp_bout});
    end
  endtask

  initial begin
    int pulses, prev;
    rst = 1'b1;
    #1;
    chk("rst_busy", 0, {8'b0, bus4.busy}, 9'd0);
    chk("rst_done", 0, {8'b0, bus4.done}, 9'd0);
    chk("rst_res", 0, res4, 9'd0);
    chk("rst_res", 1, res8, 9'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    op4(4'b0001, 4'b1111, 1'b0, 4'b0010, 1'b1);
    op4(4'b0011, 4'b0111, 1'b0, 4'b1100, 1'b1);
    op4(4'b0111, 4'b0011, 1'b0, 4'b0100, 1'b0);
    op4(4'b1111, 4'b0001, 1'b0, 4'b1110, 1'b0);
    op4(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1);
    op4(4'b1010, 4'b1010, 1'b0, 4'b0000, 1'b0);

    // start held high; operands scrambled while running
    wait_idle();
    @(negedge clk);
    a_s = 8'h05; b_s = 8'h01; bin_s = 1'b0; start_s = 1'b1;
    pulses = 0;
    prev   = -1;
    repeat (40) begin
      @(negedge clk);
      if (bus4.done) begin
        chk("held_d", 0, {5'b0, bus4.d}, 9'h004);
        chk("held_bout", 0, {8'b0, bus4.bout}, 9'd0);
        if (prev >= 0) chk("held_spacing", 0, 9'(cyc - prev), 9'd6);
        prev = cyc;
        pulses++;
      end
      if (bus4.busy) begin
        a_s = 8'($urandom); b_s = 8'($urandom); bin_s = 1'($urandom_range(0, 1));
      end else begin
        a_s = 8'h05; b_s = 8'h01; bin_s = 1'b0;
      end
    end
    start_s = 1'b0;
    chk("held_pulses", 0, 9'(pulses >= 5), 9'd1);

    // asynchronous reset two cycles into an operation
    wait_idle();
    @(negedge clk);
    a_s = 8'h05; b_s = 8'h01; bin_s = 1'b0; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 0, {8'b0, bus4.busy}, 9'd0);
    chk("arst_done", 0, {8'b0, bus4.done}, 9'd0);
    chk("arst_res", 0, res4, 9'd0);
    chk("arst_res", 1, res8, 9'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("arst_no_done", 0, {8'b0, bus4.done}, 9'd0);
    end
    op4(4'b0111, 4'b0011, 1'b0, 4'b0100, 1'b0);

    // random traffic
    repeat (13000) begin
      @(negedge clk);
      start_s = ($urandom_range(0, 9) != 0);
      a_s     = 8'($urandom);
      b_s     = 8'($urandom);
      bin_s   = 1'($urandom_range(0, 1));
    end
    start_s = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    chk("drain", 0, 9'(acc_q[0].size()), 9'd0);
    chk("drain", 1, 9'(acc_q[1].size()), 9'd0);
    chk("op_count", 0, 9'(ops[0] >= 1000), 9'd1);
    chk("op_count", 1, 9'(ops[1] >= 1000), 9'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
